button_event_arbiter: RTL and testbench

- Collects press events from N push-button debouncers: one-cycle press pulses plus debounced held levels.
- Generates auto-repeat events while a button stays held.
- Serialises all events through a single valid/ready event port using round-robin arbitration.
- Sits between the debounce front-end and the control FSM that consumes button commands.

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_repeat_timer.sv | 75 +++++++
 rtl/button_event_arbiter.sv | 115 +++++++++++
 tb/tb_button_event_arbiter.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared types and defaults for the button event arbiter and its repeat timers.
// Default repeat timing assumes a 50 MHz core clock.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RPT   = 2'd2
  } rpt_state_t;

  localparam int          DEF_CNT_W      = 24;
  localparam logic [23:0] DEF_REPEAT_DLY = 24'd5000000;  // 100 ms
  localparam logic [23:0] DEF_REPEAT_PER = 24'd1000000;  // 20 ms

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/btn_repeat_timer.sv
// Per-button auto-repeat timer: first tick REPEAT_DLY cycles after a press, then every REPEAT_PER.
// Tick is combinational from state; release cancels without a tick, a fresh press restarts the delay.
module btn_repeat_timer
  import btn_pkg::*;
#(
  parameter int              CNT_W      = DEF_CNT_W,
  parameter logic [CNT_W-1:0] REPEAT_DLY = CNT_W'(DEF_REPEAT_DLY),
  parameter logic [CNT_W-1:0] REPEAT_PER = CNT_W'(DEF_REPEAT_PER),
  parameter bit              REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_press,
  input  logic i_held,
  output logic o_tick
);

  localparam logic [CNT_W-1:0] DLY_LD = REPEAT_DLY - CNT_W'(1);
  localparam logic [CNT_W-1:0] PER_LD = REPEAT_PER - CNT_W'(1);

  rpt_state_t       r_state;
  rpt_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    o_tick      = 1'b0;
    if (!REPEAT_EN) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_press) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = DLY_LD;
          end
        end
        DELAY, RPT: begin
          // A press outranks both release and tick: the arbiter will carry the press instead.
          if (i_press) begin
            w_state_nxt = DELAY;
            w_cnt_nxt   = DLY_LD;
          end else if (!i_held) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == '0) begin
            o_tick      = 1'b1;
            w_state_nxt = RPT;
            w_cnt_nxt   = PER_LD;
          end else begin
            w_cnt_nxt   = r_cnt - CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Merges press pulses and auto-repeat ticks from N_BTN buttons into one valid/ready event stream.
// Round-robin pick into an output register; one event per cycle; events arriving on an occupied slot are dropped and flagged.
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter int               N_BTN      = 4,
  parameter int               CNT_W      = DEF_CNT_W,
  parameter logic [CNT_W-1:0] REPEAT_DLY = CNT_W'(DEF_REPEAT_DLY),
  parameter logic [CNT_W-1:0] REPEAT_PER = CNT_W'(DEF_REPEAT_PER),
  parameter bit               REPEAT_EN  = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_BTN-1:0]          press_pulse,
  input  logic [N_BTN-1:0]          held,
  output logic                      evt_valid,
  input  logic                      evt_ready,
  output logic [idx_w(N_BTN)-1:0]   evt_id,
  output logic                      evt_repeat,
  output logic [N_BTN-1:0]          overrun,
  input  logic                      overrun_clr
);

  localparam int            IW = idx_w(N_BTN);
  localparam logic [IW:0]   NB = (IW+1)'(N_BTN);

  logic [N_BTN-1:0]   w_tick;
  logic [N_BTN-1:0]   w_new;
  logic [N_BTN-1:0]   w_grant;
  logic [N_BTN-1:0]   w_ovr_set;
  logic [2*N_BTN-1:0] w_dbl;
  logic [IW:0]        w_off;
  logic [IW:0]        w_sum;
  logic [IW:0]        w_win1;
  logic [IW-1:0]      w_win;
  logic [IW-1:0]      w_ptr_nxt;
  logic               w_any;
  logic               w_load;

  logic [N_BTN-1:0]   r_pending;
  logic [N_BTN-1:0]   r_pend_rep;
  logic [N_BTN-1:0]   r_overrun;
  logic [IW-1:0]      r_ptr;
  logic               r_evt_valid;
  logic [IW-1:0]      r_evt_id;
  logic               r_evt_rep;

  for (genvar g = 0; g < N_BTN; g++) begin : g_tmr
    btn_repeat_timer #(
      .CNT_W      (CNT_W),
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER),
      .REPEAT_EN  (REPEAT_EN)
    ) u_tmr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_press (press_pulse[g]),
      .i_held  (held[g]),
      .o_tick  (w_tick[g])
    );
  end

  // Rotate pending so that bit 0 is the pointer position, then find the first set bit.
  always_comb begin
    w_dbl = {r_pending, r_pending} >> r_ptr;
    w_off = '0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (w_dbl[k]) w_off = (IW+1)'(k);
    end
    w_any     = |r_pending;
    w_sum     = {1'b0, r_ptr} + w_off;
    w_win     = (w_sum >= NB) ? IW'(w_sum - NB) : IW'(w_sum);
    w_win1    = {1'b0, w_win} + (IW+1)'(1);
    w_ptr_nxt = (w_win1 >= NB) ? '0 : IW'(w_win1);
  end

  assign w_load    = !r_evt_valid || evt_ready;
  assign w_grant   = (w_load && w_any) ? (N_BTN'(1) << w_win) : '0;
  assign w_new     = press_pulse | w_tick;
  assign w_ovr_set = w_new & r_pending & ~w_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending  <= '0;
      r_pend_rep <= '0;
      r_overrun  <= '0;
    end else begin
      r_pending  <= (r_pending & ~w_grant) | w_new;
      r_pend_rep <= (r_pend_rep & ~w_new) | (w_tick & ~press_pulse);
      r_overrun  <= (overrun_clr ? '0 : r_overrun) | w_ovr_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_evt_valid <= 1'b0;
      r_evt_id    <= '0;
      r_evt_rep   <= 1'b0;
      r_ptr       <= '0;
    end else if (w_load) begin
      r_evt_valid <= w_any;
      if (w_any) begin
        r_evt_id  <= w_win;
        r_evt_rep <= r_pend_rep[w_win];
        r_ptr     <= w_ptr_nxt;
      end
    end
  end

  assign evt_valid  = r_evt_valid;
  assign evt_id     = r_evt_id;
  assign evt_repeat = r_evt_rep;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter with a scoreboard of expected events checked at each handshake.
module tb_button_event_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] press_pulse;
  logic [3:0] held;
  logic       evt_valid;
  logic       evt_ready;
  logic [1:0] evt_id;
  logic       evt_repeat;
  logic [3:0] overrun;
  logic       overrun_clr;

  typedef struct {
    logic [1:0] id;
    logic       rep;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   p_cyc;

  button_event_arbiter #(
    .N_BTN      (4),
    .CNT_W      (24),
    .REPEAT_DLY (24'd8),
    .REPEAT_PER (24'd4),
    .REPEAT_EN  (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_pulse (press_pulse),
    .held        (held),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_repeat  (evt_repeat),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [1:0] id, input logic rep, input int c);
    exp_t e;
    e.id  = id;
    e.rep = rep;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  // Handshake monitor: every accepted event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && evt_valid && evt_ready) begin
      n_vec++;
      assert (sb_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_unexpected: observed id %0d rep %0d, expected no event", evt_id, evt_repeat);
      end
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_id", 32'(evt_id), 32'(e.id));
        check("sb_rep", 32'(evt_repeat), 32'(e.rep));
        if (e.cyc >= 0) check("sb_cyc", cyc, e.cyc);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no completion, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    press_pulse = '0;
    held        = '0;
    evt_ready   = 1'b1;
    overrun_clr = 1'b0;
    rst_n       = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check("rst_valid", 32'(evt_valid), 0);
    check("rst_id", 32'(evt_id), 0);
    check("rst_rep", 32'(evt_repeat), 0);
    check("rst_ovr", 32'(overrun), 0);
    tick_clk(2);
    rst_n = 1'b1;
    tick_clk(2);

    // Reset while an event is presented and a dropped event has flagged overrun.
    evt_ready   = 1'b0;
    press_pulse = 4'b0100;
    tick_clk(1);
    press_pulse = 4'b0010;
    tick_clk(1);
    tick_clk(1);
    press_pulse = 4'b0000;
    check("pre_rst_valid", 32'(evt_valid), 1);
    check("pre_rst_id", 32'(evt_id), 2);
    check("pre_rst_ovr", 32'(overrun), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(evt_valid), 0);
    check("arst_id", 32'(evt_id), 0);
    check("arst_rep", 32'(evt_repeat), 0);
    check("arst_ovr", 32'(overrun), 0);
    tick_clk(1);
    rst_n     = 1'b1;
    evt_ready = 1'b1;
    tick_clk(4);
    check("post_rst_idle", 32'(evt_valid), 0);

    // Simultaneous presses, then all four after the pointer has wrapped.
    press_pulse = 4'b1011;
    push(2'd0, 1'b0, -1);
    push(2'd1, 1'b0, -1);
    push(2'd3, 1'b0, -1);
    tick_clk(1);
    press_pulse = 4'b0000;
    tick_clk(3);
    press_pulse = 4'b1111;
    push(2'd0, 1'b0, -1);
    push(2'd1, 1'b0, -1);
    push(2'd2, 1'b0, -1);
    push(2'd3, 1'b0, -1);
    tick_clk(1);
    press_pulse = 4'b0000;
    tick_clk(6);
    check("rr_drained", 32'(evt_valid), 0);

    // Single press latency.
    press_pulse = 4'b0100;
    push(2'd2, 1'b0, -1);
    tick_clk(1);
    press_pulse = 4'b0000;
    check("lat_e0_valid", 32'(evt_valid), 0);
    tick_clk(1);
    check("lat_e1_valid", 32'(evt_valid), 1);
    check("lat_e1_id", 32'(evt_id), 2);
    check("lat_e1_rep", 32'(evt_repeat), 0);
    tick_clk(1);
    check("lat_e2_valid", 32'(evt_valid), 0);

    // Backpressure, overrun and clear priority.
    evt_ready   = 1'b0;
    press_pulse = 4'b0010;
    push(2'd1, 1'b0, -1);
    tick_clk(1);
    press_pulse = 4'b0000;
    tick_clk(1);
    check("bp_valid", 32'(evt_valid), 1);
    check("bp_id", 32'(evt_id), 1);
    tick_clk(3);
    press_pulse = 4'b0010;
    push(2'd1, 1'b0, -1);
    tick_clk(1);
    press_pulse = 4'b0000;
    tick_clk(2);
    check("bp_hold_valid", 32'(evt_valid), 1);
    check("bp_hold_id", 32'(evt_id), 1);
    check("bp_hold_rep", 32'(evt_repeat), 0);
    check("bp_no_ovr", 32'(overrun), 0);
    press_pulse = 4'b0010;
    tick_clk(1);
    press_pulse = 4'b0000;
    check("bp_ovr_set", 32'(overrun), 32'h2);
    overrun_clr = 1'b1;
    tick_clk(1);
    overrun_clr = 1'b0;
    check("bp_ovr_clr", 32'(overrun), 0);
    press_pulse = 4'b0010;
    overrun_clr = 1'b1;
    tick_clk(1);
    press_pulse = 4'b0000;
    overrun_clr = 1'b0;
    check("bp_set_wins", 32'(overrun), 32'h2);
    overrun_clr = 1'b1;
    tick_clk(1);
    overrun_clr = 1'b0;
    evt_ready   = 1'b1;
    tick_clk(4);
    check("bp_drained", 32'(evt_valid), 0);

    // Auto-repeat on button 0 held for 30 cycles.
    press_pulse = 4'b0001;
    held        = 4'b0001;
    tick_clk(1);
    press_pulse = 4'b0000;
    p_cyc = cyc;
    push(2'd0, 1'b0, p_cyc + 1);
    for (int r = 0; r < 6; r++) push(2'd0, 1'b1, p_cyc + 9 + 4 * r);
    tick_clk(29);
    held = 4'b0000;
    tick_clk(20);
    check("rpt_all_seen", 32'(sb_q.size()), 0);
    check("rpt_idle", 32'(evt_valid), 0);

    // New press on button 3 in the cycle its pending event is granted.
    press_pulse = 4'b1000;
    tick_clk(1);
    p_cyc = cyc;
    push(2'd3, 1'b0, p_cyc + 1);
    push(2'd3, 1'b0, p_cyc + 2);
    tick_clk(1);
    press_pulse = 4'b0000;
    tick_clk(4);
    check("coll_no_ovr", 32'(overrun), 0);
    check("coll_idle", 32'(evt_valid), 0);

    tick_clk(3);
    check("sb_empty", 32'(sb_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
